// File: rtl/reg_share_arbiter_pkg.sv
// Shared types and helpers for the round-robin register-share arbiter.
// Functions are sized for the largest supported requester count (N_MAX) and take n as an argument.
package reg_share_arbiter_pkg;

   localparam int N_MAX = 8;
   localparam int N_DEF = 4;
   localparam int IDXW  = $clog2(N_DEF);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   function automatic logic [N_MAX-1:0] onehot(input int idx);
      logic [N_MAX-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Rotate the request vector so ptr sits at bit 0, then take the lowest set bit.
   function automatic int rr_pick(input logic [N_MAX-1:0] req, input int ptr, input int n);
      logic [2*N_MAX-1:0] dbl;
      logic [2*N_MAX-1:0] rot;
      int                 pick;
      dbl = '0;
      for (int i = 0; i < N_MAX; i++) begin
         if (i < n) begin
            dbl[i]     = req[i];
            dbl[i + n] = req[i];
         end
      end
      rot  = dbl >> ptr;
      pick = 0;
      for (int j = N_MAX - 1; j >= 0; j--) begin
         if (j < n && rot[j]) pick = (ptr + j) % n;
      end
      return pick;
   endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick_comb.sv
// Combinational round-robin winner selection: first set request at or after ptr, wrapping.
module rr_pick_comb
   import reg_share_arbiter_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int IDXW = reg_share_arbiter_pkg::IDXW
) (
   input  logic [N-1:0]    req_i,
   input  logic [IDXW-1:0] ptr_i,
   output logic [IDXW-1:0] winner_o,
   output logic            any_o
);

   logic [N_MAX-1:0] req_ext;

   assign req_ext  = N_MAX'(req_i);
   assign winner_o = IDXW'(rr_pick(req_ext, int'(ptr_i), N));
   assign any_o    = |req_i;

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that sequences N requesters onto one shared W-bit register,
// bounding each tenure to MAX_HOLD written cycles.
module reg_share_arbiter
   import reg_share_arbiter_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int W        = 8,
   parameter int MAX_HOLD = 8
) (
   input  logic                                    clk,
   input  logic                                    a_reset_n,
   input  logic [N-1:0]                            req,
   input  logic [N*W-1:0]                          wdata,
   output logic [N-1:0]                            gnt,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0]    owner,
   output logic                                    busy,
   output logic [W-1:0]                            q,
   output logic                                    q_valid
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int HW = $clog2(MAX_HOLD + 1);

   state_e          state_q;
   logic [N-1:0]    gnt_q;
   logic [IW-1:0]   owner_q;
   logic            busy_q;
   logic [W-1:0]    q_q;
   logic            q_valid_q;
   logic [IW-1:0]   ptr_q;
   logic [HW-1:0]   hold_cnt_q;

   logic [IW-1:0]   winner;
   logic            any_req;
   logic            owner_req;
   logic [W-1:0]    owner_data;
   logic            last_beat;
   logic [IW-1:0]   ptr_d;

   rr_pick_comb #(
      .N    (N),
      .IDXW (IW)
   ) u_pick (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .winner_o (winner),
      .any_o    (any_req)
   );

   assign owner_req  = req[owner_q];
   assign owner_data = wdata[owner_q*W +: W];
   assign last_beat  = (hold_cnt_q == HW'(MAX_HOLD - 1));
   // The released owner drops to lowest priority on the next arbitration.
   assign ptr_d      = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge a_reset_n) begin
      if (!a_reset_n) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         owner_q    <= '0;
         busy_q     <= 1'b0;
         q_q        <= '0;
         q_valid_q  <= 1'b0;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  state_q    <= GRANT;
                  gnt_q      <= N'(onehot(int'(winner)));
                  owner_q    <= winner;
                  busy_q     <= 1'b1;
                  hold_cnt_q <= '0;
               end
            end
            GRANT: begin
               if (owner_req) begin
                  q_q        <= owner_data;
                  q_valid_q  <= 1'b1;
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
               // A timeout release still commits the final write above.
               if (!owner_req || last_beat) begin
                  state_q <= IDLE;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  ptr_q   <= ptr_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign owner   = owner_q;
   assign busy    = busy_q;
   assign q       = q_q;
   assign q_valid = q_valid_q;

endmodule
